// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants for the FIFO stream reader: skid-buffer state
// encoding, counter widths and parameter defaults.
package fifo_stream_reader_pkg;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_TWO   = 2'd2
   } skid_state_e;

   localparam int unsigned BURST_CNT_W   = 16;
   localparam int unsigned BEAT_CNT_W    = 16;
   localparam int unsigned DEF_DATA_W    = 32;
   localparam int unsigned DEF_BURST_LEN = 16;

   // Beat index that closes a full-length burst.
   function automatic logic [BEAT_CNT_W-1:0] last_beat(
      input int unsigned len
   );
      return BEAT_CNT_W'(len - 1);
   endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Stream bundle between FIFO read side, reader and downstream sink.
// master: the reader (drives o_*); slave: the environment (drives i_*).
interface fifo_stream_reader_if #(
   parameter int unsigned INT_DATA_WIDTH = 32
);
   logic [INT_DATA_WIDTH-1:0] i_data;
   logic                      i_valid;
   logic                      o_ready;
   logic [INT_DATA_WIDTH-1:0] o_data;
   logic                      o_valid;
   logic                      o_last;
   logic                      i_dready;

   modport master (
      input  i_data, i_valid, i_dready,
      output o_ready, o_data, o_valid, o_last
   );

   modport slave (
      output i_data, i_valid, i_dready,
      input  o_ready, o_data, o_valid, o_last
   );
endinterface

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer (OUT + SKD) with registered in_ready.
// Ports: clk/rst_n, in_* upstream handshake, out_* downstream handshake.
module stream_skid_buf
   import fifo_stream_reader_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_DATA_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   skid_state_e      state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] skd_q, skd_d;
   logic             rdy_q, rdy_d;
   logic             in_hs;
   logic             out_hs;

   assign out_valid = (state_q != SKID_EMPTY);
   assign out_data  = out_q;
   assign in_ready  = rdy_q;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skd_d   = skd_q;
      in_hs   = in_valid & rdy_q;
      out_hs  = out_valid & out_ready;
      unique case (state_q)
         SKID_EMPTY: begin
            if (in_hs) begin
               out_d   = in_data;
               state_d = SKID_ONE;
            end
         end
         SKID_ONE: begin
            if (in_hs && out_hs) begin
               out_d = in_data;
            end else if (in_hs) begin
               skd_d   = in_data;
               state_d = SKID_TWO;
            end else if (out_hs) begin
               state_d = SKID_EMPTY;
            end
         end
         SKID_TWO: begin
            // in_ready is low here, so only the drain path exists.
            if (out_hs) begin
               out_d   = skd_q;
               state_d = SKID_ONE;
            end
         end
         default: state_d = SKID_EMPTY;
      endcase
      rdy_d = (state_d != SKID_TWO);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SKID_EMPTY;
         out_q   <= '0;
         skd_q   <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         skd_q   <= skd_d;
         rdy_q   <= rdy_d;
      end
   end

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads a FIFO stream through a skid buffer and cuts it into bursts.
// Ports: rd_clk/rd_rst_n, sif stream bundle, i_flush, o_burst_cnt, o_busy.
module fifo_stream_reader
   import fifo_stream_reader_pkg::*;
#(
   parameter int unsigned INT_DATA_WIDTH = DEF_DATA_W,
   parameter int unsigned INT_BURST_LEN  = DEF_BURST_LEN
) (
   input  logic                   rd_clk,
   input  logic                   rd_rst_n,
   fifo_stream_reader_if.master   sif,
   input  logic                   i_flush,
   output logic [BURST_CNT_W-1:0] o_burst_cnt,
   output logic                   o_busy
);

   localparam logic [BEAT_CNT_W-1:0] LAST_BEAT =
      last_beat(INT_BURST_LEN);

   logic                   valid;
   logic                   last;
   logic                   out_hs;
   logic [BEAT_CNT_W-1:0]  beat_q, beat_d;
   logic                   flush_q, flush_d;
   logic [BURST_CNT_W-1:0] bcnt_q, bcnt_d;

   stream_skid_buf #(
      .WIDTH(INT_DATA_WIDTH)
   ) u_skid (
      .clk      (rd_clk),
      .rst_n    (rd_rst_n),
      .in_data  (sif.i_data),
      .in_valid (sif.i_valid),
      .in_ready (sif.o_ready),
      .out_data (sif.o_data),
      .out_valid(valid),
      .out_ready(sif.i_dready)
   );

   assign last        = (beat_q == LAST_BEAT) | flush_q;
   assign out_hs      = valid & sif.i_dready;
   assign sif.o_valid = valid;
   assign sif.o_last  = last;
   assign o_busy      = valid;
   assign o_burst_cnt = bcnt_q;

   always_comb begin
      beat_d  = beat_q;
      flush_d = flush_q;
      bcnt_d  = bcnt_q;
      if (out_hs) begin
         if (last) begin
            beat_d  = '0;
            bcnt_d  = bcnt_q + BURST_CNT_W'(1);
            flush_d = 1'b0;
         end else begin
            beat_d = beat_q + BEAT_CNT_W'(1);
         end
      end
      // A new flush wins over the clear, so it closes the next burst.
      if (i_flush) begin
         flush_d = 1'b1;
      end
   end

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         beat_q  <= '0;
         flush_q <= 1'b0;
         bcnt_q  <= '0;
      end else begin
         beat_q  <= beat_d;
         flush_q <= flush_d;
         bcnt_q  <= bcnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fifo_stream_reader;
   import fifo_stream_reader_pkg::*;

   localparam int DW  = 32;
   localparam int LEN = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_flush = 1'b0;
   logic [15:0] burst_cnt;
   logic        busy;

   fifo_stream_reader_if #(.INT_DATA_WIDTH(DW)) sif ();

   fifo_stream_reader #(
      .INT_DATA_WIDTH(DW),
      .INT_BURST_LEN (LEN)
   ) dut (
      .rd_clk     (clk),
      .rd_rst_n   (rst_n),
      .sif        (sif),
      .i_flush    (i_flush),
      .o_burst_cnt(burst_cnt),
      .o_busy     (busy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behavioural model: words held = queue, burst bookkeeping by rule.
   logic [DW-1:0] mq[$];
   int            mb = 0;
   bit            mf = 0;
   logic [15:0]   mbc = 0;
   bit            rdy_en = 0;
   bit            ev, er, el, ohs, ihs;

   // Observed output beats {last, data} and their cycle numbers.
   logic [DW:0]   lg[$];
   int            lc[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_o_valid", sif.o_valid, 0);
         chk("rst_o_ready", sif.o_ready, 0);
         chk("rst_o_data", sif.o_data, 0);
         chk("rst_o_last", sif.o_last, 0);
         chk("rst_burst_cnt", burst_cnt, 0);
         mq.delete();
         mb = 0;
         mf = 0;
         mbc = 0;
         rdy_en = 0;
      end else begin
         ev = (mq.size() != 0);
         er = rdy_en && (mq.size() < 2);
         el = (mb == LEN - 1) || mf;
         chk("o_valid", sif.o_valid, ev);
         chk("o_ready", sif.o_ready, er);
         chk("o_busy", busy, ev);
         chk("o_burst_cnt", burst_cnt, mbc);
         if (ev) begin
            chk("o_data", sif.o_data, mq[0]);
            chk("o_last", sif.o_last, el);
         end
         if (sif.o_valid && sif.i_dready) begin
            lg.push_back({sif.o_last, sif.o_data});
            lc.push_back(cyc);
         end
         ohs = ev && sif.i_dready;
         ihs = er && sif.i_valid;
         if (ohs) begin
            void'(mq.pop_front());
            if (el) begin
               mb = 0;
               mbc++;
            end else begin
               mb++;
            end
         end
         if (i_flush) mf = 1;
         else if (ohs && el) mf = 0;
         if (ihs) mq.push_back(sif.i_data);
         rdy_en = 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 0;
      sif.i_valid = 0;
      sif.i_dready = 0;
      i_flush = 0;
      step();
      step();
      rst_n = 1;
      step();
      lg.delete();
      lc.delete();
   endtask

   task automatic send(logic [DW-1:0] d);
      int n;
      n = 0;
      sif.i_data = d;
      sif.i_valid = 1;
      while (!sif.o_ready && n < 50) begin
         step();
         n++;
      end
      chk("send_accept", sif.o_ready, 1);
      step();
      sif.i_valid = 0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      sif.i_valid = 0;
      while (sif.o_valid && n < 50) begin
         step();
         n++;
      end
      chk("drain_done", sif.o_valid, 0);
   endtask

   task automatic chk_log(string name, int idx,
                          logic [DW-1:0] d, logic l);
      if (idx < lg.size()) begin
         chk({name, "_data"}, lg[idx][DW-1:0], d);
         chk({name, "_last"}, lg[idx][DW], l);
      end else begin
         chk({name, "_missing"}, lg.size(), idx + 1);
      end
   endtask

   initial begin
      int sent, guard;
      sif.i_data = '0;
      sif.i_valid = 0;
      sif.i_dready = 0;
      #1;
      chk("init_o_valid", sif.o_valid, 0);
      chk("init_o_ready", sif.o_ready, 0);
      chk("init_busy", busy, 0);
      step();
      step();
      rst_n = 1;
      step();
      chk("ready_after_rst", sif.o_ready, 1);

      // Full bursts, back-to-back.
      do_reset();
      sif.i_dready = 1;
      for (int i = 1; i <= 8; i++) send(i);
      drain();
      chk("b2b_count", lg.size(), 8);
      for (int i = 0; i < 8; i++)
         chk_log("b2b", i, i + 1, (i == 3) || (i == 7));
      for (int i = 1; i < lc.size(); i++)
         chk("b2b_gap", lc[i] - lc[i-1], 1);
      chk("b2b_bursts", burst_cnt, 2);

      // Downstream stall fills the skid.
      do_reset();
      sif.i_dready = 1;
      send(11);
      sif.i_dready = 0;
      send(12);
      chk("stall_ready", sif.o_ready, 0);
      chk("stall_data", sif.o_data, 11);
      sif.i_data = 13;
      sif.i_valid = 1;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("stall_hold_ready", sif.o_ready, 0);
         chk("stall_hold_data", sif.o_data, 11);
      end
      sif.i_dready = 1;
      for (int i = 13; i <= 16; i++) send(i);
      drain();
      chk("stall_count", lg.size(), 6);
      for (int i = 0; i < 6; i++)
         chk_log("stall", i, 11 + i, i == 3);

      // Early close by flush.
      do_reset();
      sif.i_dready = 1;
      send(21);
      send(22);
      i_flush = 1;
      step();
      i_flush = 0;
      drain();
      for (int i = 23; i <= 27; i++) send(i);
      drain();
      chk("flush_count", lg.size(), 7);
      for (int i = 0; i < 7; i++)
         chk_log("flush", i, 21 + i, (i == 2) || (i == 6));
      chk("flush_bursts", burst_cnt, 2);

      // Flush while empty.
      do_reset();
      sif.i_dready = 1;
      i_flush = 1;
      step();
      i_flush = 0;
      step();
      step();
      step();
      send(32'hA5);
      drain();
      chk("eflush_count", lg.size(), 1);
      chk_log("eflush", 0, 32'hA5, 1);
      chk("eflush_bursts", burst_cnt, 1);

      // Asynchronous reset while two words are held.
      do_reset();
      send(31);
      send(32);
      chk("two_ready", sif.o_ready, 0);
      chk("two_valid", sif.o_valid, 1);
      #2;
      rst_n = 0;
      #1;
      chk("async_valid", sif.o_valid, 0);
      chk("async_busy", busy, 0);
      step();
      step();
      rst_n = 1;
      step();
      lg.delete();
      lc.delete();
      sif.i_dready = 1;
      for (int i = 41; i <= 44; i++) send(i);
      drain();
      chk("post_rst_count", lg.size(), 4);
      for (int i = 0; i < 4; i++)
         chk_log("post_rst", i, 41 + i, i == 3);

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         sif.i_valid = ($urandom % 4) != 0;
         sif.i_dready = ($urandom % 3) != 0;
         i_flush = ($urandom % 16) == 0;
         sif.i_data = $urandom;
         step();
      end
      i_flush = 0;
      sif.i_dready = 1;
      drain();

      // Burst counter wrap: one-word bursts with flush held.
      do_reset();
      sif.i_dready = 1;
      i_flush = 1;
      sif.i_valid = 1;
      sent = 0;
      guard = 0;
      while (sent < 65535 && guard < 70000) begin
         sif.i_data = sent;
         if (sif.o_ready) sent++;
         step();
         guard++;
      end
      chk("wrap_sent", sent, 65535);
      drain();
      chk("wrap_full", burst_cnt, 16'hFFFF);
      send(32'h77);
      drain();
      chk("wrap_zero", burst_cnt, 0);
      i_flush = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter INT_DATA_WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter INT_BURST_LEN, default 16, words per burst; legal range 2..65535.
REQ-003 rd_clk  in  1  sole clock; all state on rising edge.
REQ-004 rd_rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_data  in  INT_DATA_WIDTH  word from FIFO read side.
REQ-006 i_valid  in  1  i_data valid (driven by FIFO o_data_valid).
REQ-007 o_ready  out  1  this block can accept a word (drives FIFO i_dready).
REQ-008 o_data  out  INT_DATA_WIDTH  output word.
REQ-009 o_valid  out  1  o_data valid.
REQ-010 o_last  out  1  marks final word of a burst; meaningful only with o_valid.
REQ-011 i_dready  in  1  downstream ready.
REQ-012 i_flush  in  1  one-cycle request to close the current burst early.
REQ-013 o_burst_cnt  out  16  completed-burst counter.
REQ-014 o_busy  out  1  high when any word is held internally.

Function
REQ-015 Input handshake = i_valid & o_ready; output handshake = o_valid & i_dready.
REQ-016 Buffering SHALL be a 2-entry skid buffer (output register OUT + skid register SKD) with states EMPTY, ONE, TWO.
REQ-017 EMPTY: input handshake -> word to OUT, go ONE.
REQ-018 ONE: input-only handshake -> word to SKD, go TWO; output-only -> EMPTY; both -> new word to OUT, stay ONE.
REQ-019 TWO: output handshake -> SKD moves to OUT, go ONE; no input accepted in TWO.
REQ-020 o_ready SHALL be registered and equal (state != TWO); o_valid SHALL equal (state != EMPTY); o_busy SHALL equal o_valid.
REQ-021 Latency: a word accepted at edge N SHALL appear on o_data at edge N+1 when the buffer was EMPTY or drained in that cycle.
REQ-022 Sustained throughput SHALL be one word per cycle while i_valid and i_dready are both held high.
REQ-023 Word order SHALL be preserved; no word duplicated or dropped.
REQ-024 o_data and o_valid SHALL be stable while o_valid=1 and i_dready=0.
REQ-025 Beat counter (16 bits) SHALL increment on each output handshake and return to 0 on a handshake with o_last=1.
REQ-026 o_last SHALL equal (beat_cnt == INT_BURST_LEN-1) | flush_pending.
REQ-027 i_flush=1 SHALL set flush_pending at the next edge; flush_pending SHALL clear on an output handshake with o_last=1.
REQ-028 i_flush coinciding with an o_last handshake SHALL leave flush_pending set, closing the next burst after its first word.
REQ-029 i_flush while EMPTY SHALL be held pending until the next word, which is then emitted as a 1-word burst.
REQ-030 o_burst_cnt SHALL increment on every output handshake with o_last=1, wrapping 65535 -> 0.

Reset
REQ-031 Reset SHALL force: state EMPTY, o_valid=0, o_ready=0 during reset and 1 from the first edge after release, o_last=0, o_data=0, beat_cnt=0, flush_pending=0, o_burst_cnt=0.
REQ-032 Reset asserted mid-burst SHALL discard OUT and SKD contents immediately; no partial burst SHALL be resumed.

Structure
REQ-033 State encodings and the burst-counter width SHALL live in a shared header with the FIFO constants.
REQ-034 The 2-entry buffer SHALL be a sub-module stream_skid_buf; burst, flush and counter logic SHALL live in the top level.

Verification
REQ-035 INT_BURST_LEN=4, i_valid and i_dready held high, words 1..8 -> 1..8 output back-to-back; o_last on words 4 and 8; o_burst_cnt=2.
REQ-036 i_dready low 3 cycles mid-stream -> o_ready falls after exactly 2 words are held, no loss, order preserved, o_data stable.
REQ-037 i_flush pulsed after 2 of 4 words -> next output word (3rd) carries o_last; following burst restarts at beat 0.
REQ-038 i_flush while EMPTY, then one word 0xA5 -> 0xA5 emitted with o_last=1; o_burst_cnt +1.
REQ-039 o_burst_cnt preset by 65535 bursts, one more burst -> wraps to 0.
REQ-040 rd_rst_n low while TWO -> o_valid=0 asynchronously; after release, first accepted word is the first output with beat 0.
